alu_seq: RTL

//   Parametrised multi-cycle ALU; successor to the 3-bit-function combinational ALU.
//   - Keeps the legacy AND/OR/ADD/SUB/SLT op set (op[3]=0).
//   - Adds shifts, SLTU, XOR, and iterative unsigned MUL/DIVU/REMU.
//   - Operands arrive and results leave over valid/ready handshakes, so the block

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_muldiv_iter.sv | 67 ++++++
 rtl/alu_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, FSM states and the
// classification helper used by the top level.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND    = 4'b0000,
        OP_OR     = 4'b0001,
        OP_ADD    = 4'b0010,
        OP_ADDMSB = 4'b0011,
        OP_ANDN   = 4'b0100,
        OP_ORN    = 4'b0101,
        OP_SUB    = 4'b0110,
        OP_SLT    = 4'b0111,
        OP_SLL    = 4'b1000,
        OP_SRL    = 4'b1001,
        OP_SRA    = 4'b1010,
        OP_SLTU   = 4'b1011,
        OP_MUL    = 4'b1100,
        OP_DIVU   = 4'b1101,
        OP_REMU   = 4'b1110,
        OP_XOR    = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Iterative unit modes; these equal op[1:0] of the matching op codes.
    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_DIVU = 2'b01;
    localparam logic [1:0] MD_REMU = 2'b10;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per step,
// with both algorithms sharing a single N-bit adder.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         step,
    output logic [N-1:0] result
);

    // r0: product accumulator / partial remainder
    // r1: shifted multiplicand / dividend becoming quotient
    // r2: multiplier bits consumed LSB first / divisor
    logic [1:0]   md;
    logic [N-1:0] r0, r1, r2;
    logic         div;
    logic [N-1:0] shifted;
    logic [N-1:0] add_x, add_y;
    logic [N:0]   sum;
    logic         ge;

    // NOTE: every signal written in always_comb gets a value on all paths
    // (here unconditionally), otherwise synthesis infers a latch.
    always_comb begin
        div     = (md != MD_MUL);
        shifted = {r0[N-2:0], r1[N-1]};
        add_x   = div ? shifted : r0;
        add_y   = div ? ~r2 : r1;
        sum     = {1'b0, add_x} + {1'b0, add_y} + {{N{1'b0}}, div};
        // The dropped r0 msb makes the true shifted remainder >= 2^N > divisor.
        ge      = r0[N-1] | sum[N];
        result  = (md == MD_DIVU) ? r1 : r0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md <= MD_MUL;
            r0 <= '0;
            r1 <= '0;
            r2 <= '0;
        end else if (start) begin
            md <= mode;
            r0 <= '0;
            r1 <= a;
            r2 <= b;
        end else if (step) begin
            if (div) begin
                r0 <= ge ? sum[N-1:0] : shifted;
                r1 <= {r1[N-2:0], ge};
            end else begin
                if (r2[0]) r0 <= sum[N-1:0];
                r1 <= r1 << 1;
                r2 <= r2 >> 1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready in and out: single-cycle logic/arith/shift
// ops plus optional iterative MUL/DIVU/REMU.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N         = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         zero,
    output logic         ovf,
    output logic         carry,
    output logic         err
);

    localparam int SW = $clog2(N);

    alu_state_t    state, state_nxt;
    logic [SW-1:0] cnt;
    logic          accept, go_iter, md_step;
    logic [N-1:0]  bb;
    logic [N:0]    sum;
    logic [SW-1:0] sh;
    logic [N-1:0]  sc_y;
    logic          sc_ovf, sc_carry, sc_err;
    logic [N-1:0]  y_r, mdv_result;
    logic          zero_r, ovf_r, carry_r, err_r, sel_mdv;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    // Divide by zero is resolved in the single-cycle path and never iterates.
    assign go_iter  = accept && MULDIV_EN && is_muldiv(op) &&
                      ((op == OP_MUL) || (b != '0));
    assign md_step  = (state == BUSY);

    always_comb begin
        bb       = op[2] ? ~b : b;
        sum      = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, op[2]};
        sh       = b[SW-1:0];
        sc_y     = '0;
        sc_ovf   = 1'b0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        case (alu_op_t'(op))
            OP_AND:    sc_y = a & b;
            OP_OR:     sc_y = a | b;
            OP_ADD, OP_SUB: begin
                sc_y     = sum[N-1:0];
                sc_carry = sum[N];
                sc_ovf   = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_ADDMSB: sc_y = {{(N-1){1'b0}}, sum[N-1]};
            OP_ANDN:   sc_y = a & bb;
            OP_ORN:    sc_y = a | bb;
            OP_SLT:    sc_y = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLL:    sc_y = a << sh;
            OP_SRL:    sc_y = a >> sh;
            OP_SRA:    sc_y = $unsigned($signed(a) >>> sh);
            OP_SLTU:   sc_y = {{(N-1){1'b0}}, a < b};
            OP_XOR:    sc_y = a ^ b;
            OP_MUL:    sc_err = 1'b1;
            OP_DIVU: begin
                sc_err = 1'b1;
                sc_y   = MULDIV_EN ? {N{1'b1}} : '0;
            end
            OP_REMU: begin
                sc_err = 1'b1;
                sc_y   = MULDIV_EN ? a : '0;
            end
            default:   sc_y = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)                           state_nxt = go_iter ? BUSY : DONE;
                else if (state == DONE && out_ready)  state_nxt = IDLE;
            end
            BUSY:    if (cnt == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            y_r     <= '0;
            zero_r  <= 1'b0;
            ovf_r   <= 1'b0;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
            sel_mdv <= 1'b0;
        end else if (accept) begin
            if (go_iter) begin
                cnt     <= SW'(N - 1);
                ovf_r   <= 1'b0;
                carry_r <= 1'b0;
                err_r   <= 1'b0;
                sel_mdv <= 1'b1;
            end else begin
                y_r     <= sc_y;
                zero_r  <= (sc_y == '0);
                ovf_r   <= sc_ovf;
                carry_r <= sc_carry;
                err_r   <= sc_err;
                sel_mdv <= 1'b0;
            end
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    generate
        if (MULDIV_EN) begin : g_muldiv
            alu_muldiv_iter #(.N(N)) u_muldiv (
                .clk    (clk),
                .rst_n  (rst_n),
                .start  (go_iter),
                .mode   (op[1:0]),
                .a      (a),
                .b      (b),
                .step   (md_step),
                .result (mdv_result)
            );
        end else begin : g_no_muldiv
            assign mdv_result = '0;
        end
    endgenerate

    // Iterative results are read straight from the unit's registers, which
    // hold still outside BUSY, so the final step lands on the DONE edge.
    assign out_valid = (state == DONE);
    assign y         = sel_mdv ? mdv_result : y_r;
    assign zero      = sel_mdv ? (mdv_result == '0) : zero_r;
    assign ovf       = ovf_r;
    assign carry     = carry_r;
    assign err       = err_r;

endmodule
